// File: rtl/add_result_checker.sv
// add_result_checker: response end of the add operand stream. It checks dut_out against (in0+in1) LATENCY cycles
// after each accepted pair. Optional macro ADD_CHECK_HALT_EN stops accepting operands after the first mismatch.
module add_result_checker #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1,
  parameter int COUNT_W = 16
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_start,
  input  logic [COUNT_W-1:0] i_num_vectors,
  input  logic               i_op_valid,
  output logic               o_op_ready,
  input  logic [WIDTH-1:0]   i_in0,
  input  logic [WIDTH-1:0]   i_in1,
  input  logic [WIDTH-1:0]   i_dut_out,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [COUNT_W-1:0] o_pass_count,
  output logic [COUNT_W-1:0] o_fail_count,
  output logic [COUNT_W-1:0] o_first_fail_idx,
  output logic [WIDTH-1:0]   o_first_fail_exp,
  output logic [WIDTH-1:0]   o_first_fail_got
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  function automatic logic [WIDTH-1:0] f_expected(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return a + b;
  endfunction

  state_t             r_state;
  logic               r_op_ready;
  logic               r_busy;
  logic               r_done;
  logic               r_pass;
  logic [COUNT_W-1:0] r_num;
  logic [COUNT_W-1:0] r_idx;
  logic [COUNT_W-1:0] r_pass_cnt;
  logic [COUNT_W-1:0] r_fail_cnt;
  logic [COUNT_W-1:0] r_ff_idx;
  logic [WIDTH-1:0]   r_ff_exp;
  logic [WIDTH-1:0]   r_ff_got;

  logic               r_pv   [LATENCY];
  logic [WIDTH-1:0]   r_pexp [LATENCY];
  logic [COUNT_W-1:0] r_pidx [LATENCY];

  logic               w_accept;
  logic               w_cmp_valid;
  logic               w_mismatch;
  logic               w_last_accept;
  logic               w_halt;
  logic               w_inflight;
  logic [WIDTH-1:0]   w_exp_in;
  logic [COUNT_W-1:0] w_idx_inc;

  // Accept/compare decode; w_inflight ignores the last stage, which is compared on this same edge
  always_comb begin
    w_accept      = i_op_valid & r_op_ready;
    w_exp_in      = f_expected(i_in0, i_in1);
    w_idx_inc     = r_idx + CNT_ONE;
    w_cmp_valid   = r_pv[LATENCY-1];
    w_mismatch    = w_cmp_valid & (i_dut_out != r_pexp[LATENCY-1]);
    w_last_accept = w_accept & (w_idx_inc == r_num);
    w_inflight    = 1'b0;
    for (int i = 0; i < LATENCY - 1; i++) begin
      w_inflight = w_inflight | r_pv[i];
    end
`ifdef ADD_CHECK_HALT_EN
    w_halt = w_mismatch & (r_fail_cnt == '0);
`else
    w_halt = 1'b0;
`endif
  end

  // Expected-value pipeline: one stage per cycle of DUT latency, bubbles travel as valid=0
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_pv[i]   <= 1'b0;
        r_pexp[i] <= '0;
        r_pidx[i] <= '0;
      end
    end else begin
      r_pv[0]   <= w_accept;
      r_pexp[0] <= w_exp_in;
      r_pidx[0] <= r_idx;
      for (int i = 1; i < LATENCY; i++) begin
        r_pv[i]   <= r_pv[i-1];
        r_pexp[i] <= r_pexp[i-1];
        r_pidx[i] <= r_pidx[i-1];
      end
    end
  end

  // Run-control FSM together with the scoreboard counters and first-mismatch capture
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state    <= S_IDLE;
      r_op_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_num      <= '0;
      r_idx      <= '0;
      r_pass_cnt <= '0;
      r_fail_cnt <= '0;
      r_ff_idx   <= '0;
      r_ff_exp   <= '0;
      r_ff_got   <= '0;
    end else begin
      if (w_cmp_valid) begin
        if (w_mismatch) begin
          if (r_fail_cnt != CNT_MAX) begin
            r_fail_cnt <= r_fail_cnt + CNT_ONE;
          end
          if (r_fail_cnt == '0) begin
            r_ff_idx <= r_pidx[LATENCY-1];
            r_ff_exp <= r_pexp[LATENCY-1];
            r_ff_got <= i_dut_out;
          end
        end else if (r_pass_cnt != CNT_MAX) begin
          r_pass_cnt <= r_pass_cnt + CNT_ONE;
        end
      end
      if (w_accept) begin
        r_idx <= w_idx_inc;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_num      <= i_num_vectors;
            r_idx      <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_ff_idx   <= '0;
            r_ff_exp   <= '0;
            r_ff_got   <= '0;
            if (i_num_vectors == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_state    <= S_RUN;
              r_op_ready <= 1'b1;
              r_busy     <= 1'b1;
              r_done     <= 1'b0;
              r_pass     <= 1'b0;
            end
          end
        end
        S_RUN: begin
          if (w_last_accept || w_halt) begin
            r_state    <= S_DRAIN;
            r_op_ready <= 1'b0;
          end
        end
        S_DRAIN: begin
          // The final compare lands on the same edge that enters DONE
          if (!w_inflight) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_fail_cnt == '0) && !w_mismatch;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_op_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_pass     <= 1'b0;
        end
      endcase
    end
  end

  assign o_op_ready       = r_op_ready;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_pass           = r_pass;
  assign o_pass_count     = r_pass_cnt;
  assign o_fail_count     = r_fail_cnt;
  assign o_first_fail_idx = r_ff_idx;
  assign o_first_fail_exp = r_ff_exp;
  assign o_first_fail_got = r_ff_got;

endmodule
